mem_stage_ctrl: RTL and testbench

Memory-stage controller sitting directly downstream of the EX/MEM pipeline register. It consumes the EX/MEM control/data outputs and drives a variable-latency data-memory request/acknowledge handshake. It asserts `stall` to freeze EX/MEM and earlier stages while an access is outstanding. It owns the MEM/WB register bank that feeds write-back.

---
 rtl/mem_stage_ctrl_if.sv | 23 ++
 rtl/mem_stage_ctrl.sv | 142 ++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge bus between the memory-stage controller
// and the variable-latency data memory.
interface mem_stage_ctrl_if;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_dump;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  // Controller side: issues requests, receives completion and read data.
  modport master (
    output mem_req, mem_wr, mem_addr, mem_wdata, mem_dump,
    input  mem_ack, mem_rdata
  );

  // Memory side: accepts requests, returns completion and read data.
  modport slave (
    input  mem_req, mem_wr, mem_addr, mem_wdata, mem_dump,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: sits behind EX/MEM, runs one data-memory access
// per load/store over a req/ack handshake, stalls the front of the pipe while
// the access is outstanding, and owns the MEM/WB register bank.
module mem_stage_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        createdump_i,
  input  logic        write_mem_i,
  input  logic        read_mem_i,
  input  logic        mem_to_reg_i,
  input  logic        reg_w_en_i,
  input  logic [2:0]  w_reg_i,
  input  logic [15:0] data_2_i,
  input  logic [15:0] ALU_out_i,
  mem_stage_ctrl_if.master mem,
  output logic        stall,
  output logic        wb_mem_to_reg,
  output logic        wb_reg_w_en,
  output logic [2:0]  wb_w_reg,
  output logic [15:0] wb_mem_data,
  output logic [15:0] wb_ALU_out,
  output logic        halted,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    DONE   = 3'd2,
    HALT   = 3'd3,
    FAULT  = 3'd4
  } state_t;

  // Counter value on the last ACCESS cycle allowed before giving up.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [15:0] rdata_q;
  logic        dump_q;
  logic        mem_op;

  assign mem_op = read_mem_i | write_mem_i;

  // The request lines come straight from state and the latched request regs,
  // so they stay stable for the whole access and drop at once on reset.
  assign mem.mem_req   = (state == ACCESS);
  assign mem.mem_wr    = req_wr;
  assign mem.mem_addr  = req_addr;
  assign mem.mem_wdata = req_wdata;
  assign mem.mem_dump  = dump_q;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state selection and the combinational stall to EX/MEM and upstream.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    unique case (state)
      IDLE: begin
        stall = createdump_i | mem_op;
        if (createdump_i)   state_nxt = HALT;
        else if (mem_op)    state_nxt = ALU_out_i[0] ? FAULT : ACCESS;
      end
      ACCESS: begin
        stall = 1'b1;
        if (mem.mem_ack)          state_nxt = DONE;
        else if (cnt == CNT_LAST) state_nxt = FAULT;
      end
      DONE:  state_nxt = IDLE;
      HALT:  stall = 1'b1;
      FAULT: stall = 1'b1;
      default: begin
        state_nxt = IDLE;
        stall     = 1'b1;
      end
    endcase
    // Nothing upstream should be held while the controller is in reset.
    if (!rst) stall = 1'b0;
  end

  // Request latch, wait counter, read-data capture, dump pulse and sticky flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      req_wr    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      rdata_q   <= '0;
      dump_q    <= 1'b0;
      halted    <= 1'b0;
      err       <= 1'b0;
    end else begin
      dump_q <= 1'b0;
      if (state == IDLE && !createdump_i && mem_op && !ALU_out_i[0]) begin
        cnt       <= '0;
        req_wr    <= write_mem_i;
        req_addr  <= ALU_out_i;
        req_wdata <= data_2_i;
      end
      if (state == ACCESS) begin
        if (mem.mem_ack) rdata_q <= req_wr ? 16'h0000 : mem.mem_rdata;
        else             cnt     <= cnt + 8'd1;
      end
      if (state == IDLE && state_nxt == HALT) begin
        dump_q <= 1'b1;
        halted <= 1'b1;
      end
      if (state != FAULT && state_nxt == FAULT) err <= 1'b1;
    end
  end

  // MEM/WB bank: bubble while stalled, otherwise capture the instruction leaving MEM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_mem_to_reg <= 1'b0;
      wb_reg_w_en   <= 1'b0;
      wb_w_reg      <= '0;
      wb_mem_data   <= '0;
      wb_ALU_out    <= '0;
    end else if (stall) begin
      wb_mem_to_reg <= 1'b0;
      wb_reg_w_en   <= 1'b0;
    end else begin
      wb_mem_to_reg <= mem_to_reg_i;
      wb_reg_w_en   <= reg_w_en_i;
      wb_w_reg      <= w_reg_i;
      wb_ALU_out    <= ALU_out_i;
      wb_mem_data   <= (state == DONE) ? rdata_q : 16'h0000;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with a short access timeout.
module tb_mem_stage_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        createdump_i, write_mem_i, read_mem_i, mem_to_reg_i, reg_w_en_i;
  logic [2:0]  w_reg_i;
  logic [15:0] data_2_i, ALU_out_i;
  logic        stall, wb_mem_to_reg, wb_reg_w_en, halted, err;
  logic [2:0]  wb_w_reg;
  logic [15:0] wb_mem_data, wb_ALU_out;

  int n_chk  = 0;
  int n_pass = 0;
  int ns, nr, nbad, ndump;

  mem_stage_ctrl_if bus ();

  mem_stage_ctrl #(.TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .createdump_i  (createdump_i),
    .write_mem_i   (write_mem_i),
    .read_mem_i    (read_mem_i),
    .mem_to_reg_i  (mem_to_reg_i),
    .reg_w_en_i    (reg_w_en_i),
    .w_reg_i       (w_reg_i),
    .data_2_i      (data_2_i),
    .ALU_out_i     (ALU_out_i),
    .mem           (bus.master),
    .stall         (stall),
    .wb_mem_to_reg (wb_mem_to_reg),
    .wb_reg_w_en   (wb_reg_w_en),
    .wb_w_reg      (wb_w_reg),
    .wb_mem_data   (wb_mem_data),
    .wb_ALU_out    (wb_ALU_out),
    .halted        (halted),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic dump, input logic rd, input logic wr, input logic m2r,
                        input logic wen, input logic [2:0] wreg, input logic [15:0] d2,
                        input logic [15:0] alu);
    createdump_i = dump; read_mem_i = rd; write_mem_i = wr; mem_to_reg_i = m2r;
    reg_w_en_i = wen; w_reg_i = wreg; data_2_i = d2; ALU_out_i = alu;
  endtask

  task automatic nop();
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
  endtask

  // Runs cycles until stall drops or the budget expires; acks on the
  // ack_at-th request cycle (0 = never) and counts request-line instability.
  task automatic run_access(input int ack_at, input logic [15:0] rd, input int budget,
                            input logic exp_wr, input logic [15:0] exp_addr,
                            input logic [15:0] exp_wdata,
                            output int n_stall, output int n_req, output int n_bad);
    n_stall = 0; n_req = 0; n_bad = 0;
    for (int c = 0; c < budget; c++) begin
      #1;
      if (!stall) break;
      n_stall++;
      if (c > 0 && wb_reg_w_en) n_bad++;
      if (bus.mem_req) begin
        n_req++;
        if (bus.mem_wr !== exp_wr || bus.mem_addr !== exp_addr ||
            (exp_wr && bus.mem_wdata !== exp_wdata)) n_bad++;
        if (n_req == ack_at) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = rd;
        end
      end
      @(posedge clk);
      #1;
      bus.mem_ack = 1'b0;
      bus.mem_rdata = 16'h0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #3;
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  initial begin
    nop();
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 16'h0;
    rst = 1'b0;
    #12;
    check("rst_stall", stall, 0);
    check("rst_req", bus.mem_req, 0);
    check("rst_err_halted", {err, halted, bus.mem_dump}, 0);
    check("rst_wb", {wb_reg_w_en, wb_mem_to_reg, wb_w_reg, wb_ALU_out, wb_mem_data}, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Pass-through ALU op
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 16'h0, 16'h1234);
    #1;
    check("alu_stall", stall, 0);
    tick();
    nop();
    check("alu_wb_wen", wb_reg_w_en, 1);
    check("alu_wb_wreg", wb_w_reg, 3);
    check("alu_wb_alu", wb_ALU_out, 16'h1234);
    check("alu_wb_mdata", wb_mem_data, 0);

    // Load, ack on the 3rd ACCESS cycle
    set_op(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 16'h0, 16'h0010);
    run_access(3, 16'hBEEF, 20, 1'b0, 16'h0010, 16'h0, ns, nr, nbad);
    check("ld_stall_cycles", ns, 4);
    check("ld_req_cycles", nr, 3);
    check("ld_bubble_stable", nbad, 0);
    check("ld_done_req", bus.mem_req, 0);
    check("ld_done_wen", wb_reg_w_en, 0);
    tick();
    nop();
    check("ld_wb_mdata", wb_mem_data, 16'hBEEF);
    check("ld_wb_m2r", wb_mem_to_reg, 1);
    check("ld_wb_wen", wb_reg_w_en, 1);
    check("ld_wb_wreg", wb_w_reg, 5);
    check("ld_wb_alu", wb_ALU_out, 16'h0010);

    // Store, ack on the 1st ACCESS cycle
    set_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'hCAFE, 16'h0020);
    run_access(1, 16'h5555, 20, 1'b1, 16'h0020, 16'hCAFE, ns, nr, nbad);
    check("st_stall_cycles", ns, 2);
    check("st_req_cycles", nr, 1);
    check("st_req_stable", nbad, 0);
    tick();
    nop();
    check("st_wb_wen", wb_reg_w_en, 0);
    check("st_wb_mdata", wb_mem_data, 0);
    check("st_wb_alu", wb_ALU_out, 16'h0020);

    // Reset while an access is in flight
    set_op(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd6, 16'h0, 16'h0050);
    tick();
    tick();
    check("mid_req_before", bus.mem_req, 1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_req_async", bus.mem_req, 0);
    check("mid_stall_async", stall, 0);
    check("mid_wb_async", {wb_reg_w_en, wb_mem_to_reg, wb_w_reg, wb_ALU_out, wb_mem_data}, 0);
    nop();
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Unaligned load
    set_op(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 16'h0, 16'h0011);
    #1;
    check("ua_stall_detect", stall, 1);
    nr = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      nop();
      if (bus.mem_req) nr++;
    end
    check("ua_req_never", nr, 0);
    check("ua_err", err, 1);
    check("ua_stall_held", stall, 1);
    do_reset();
    check("ua_err_cleared", err, 0);

    // Timeout with no ack
    set_op(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 16'h0, 16'h0040);
    run_access(0, 16'h0, 10, 1'b0, 16'h0040, 16'h0, ns, nr, nbad);
    check("to_req_cycles", nr, 4);
    check("to_stall_held", ns, 10);
    check("to_err", err, 1);
    check("to_req_low", bus.mem_req, 0);
    nop();
    do_reset();

    // Dump together with a read
    set_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0010);
    #1;
    check("dump_stall_detect", stall, 1);
    check("dump_not_yet", bus.mem_dump, 0);
    tick();
    nop();
    check("dump_pulse", bus.mem_dump, 1);
    check("dump_halted", halted, 1);
    ndump = 1; nr = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus.mem_dump) ndump++;
      if (bus.mem_req) nr++;
    end
    check("dump_single", ndump, 1);
    check("dump_no_req", nr, 0);
    check("dump_halted_sticky", halted, 1);
    check("dump_stall_held", stall, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, %0d/%0d done", n_pass, n_chk);
    $fatal(1);
  end
endmodule
